// File: rtl/udalt_sweep_ctrl_pkg.sv
// rtl/udalt_sweep_ctrl_pkg.sv - shared state encoding and sweep length helper for the sweep sequencer
package udalt_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // One triangle sweep 0 -> MAX -> 0 takes 2*MAX counter enables.
  function automatic int sweep_steps(input int cnt_w);
    return 2 * ((1 << cnt_w) - 1);
  endfunction

endpackage

// File: rtl/udalt_prescaler.sv
// rtl/udalt_prescaler.sv - programmable enable prescaler; ticks when the count reaches period-1
module udalt_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             hold_i,
  input  logic [PRE_W-1:0] period_m1_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick_o = (pre_cnt_q == period_m1_i);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear_i) begin
      pre_cnt_d = '0;
    end else if (!hold_i) begin
      pre_cnt_d = tick_o ? '0 : pre_cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/udalt_sweep_ctrl.sv
// rtl/udalt_sweep_ctrl.sv - clears the up/down counter, paces its enable and counts completed sweeps
module udalt_sweep_ctrl
  import udalt_sweep_ctrl_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int PRE_W = 8,
  parameter int SWP_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic [PRE_W-1:0] prescale_i,
  input  logic [SWP_W-1:0] num_sweeps_i,
  output logic             cnt_reset_o,
  output logic             cnt_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [SWP_W-1:0] sweeps_done_o
);

  localparam int SWEEP_STEPS = sweep_steps(CNT_W);
  localparam int STEP_W      = $clog2(SWEEP_STEPS);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_lat_q, pre_lat_d;
  logic [SWP_W-1:0] num_lat_q, num_lat_d;
  logic [SWP_W-1:0] sweeps_q, sweeps_d, sweeps_inc;
  logic [STEP_W-1:0] step_q, step_d;
  logic             pre_tick;
  logic             sweep_wrap;
  logic             complete;

  udalt_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (state_q == ST_CLEAR),
    .hold_i     (state_q != ST_RUN),
    .period_m1_i(pre_lat_q),
    .tick_o     (pre_tick)
  );

  assign cnt_reset_o   = (state_q == ST_CLEAR);
  assign cnt_en_o      = (state_q == ST_RUN) && pre_tick;
  assign busy_o        = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign done_o        = (state_q == ST_DONE);
  assign sweeps_done_o = sweeps_q;

  assign sweeps_inc = sweeps_q + SWP_W'(1);
  assign sweep_wrap = cnt_en_o && (step_q == STEP_W'(SWEEP_STEPS - 1));
  assign complete   = sweep_wrap && (num_lat_q != '0) && (sweeps_inc == num_lat_q);

  // Step/sweep counters follow every issued enable, even when stop overrides completion.
  always_comb begin
    state_d   = state_q;
    pre_lat_d = pre_lat_q;
    num_lat_d = num_lat_q;
    step_d    = step_q;
    sweeps_d  = sweeps_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d   = ST_CLEAR;
          pre_lat_d = prescale_i;
          num_lat_d = num_sweeps_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        step_d   = '0;
        sweeps_d = '0;
        state_d  = stop_i ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (cnt_en_o) begin
          step_d = sweep_wrap ? '0 : step_q + STEP_W'(1);
          if (sweep_wrap) begin
            sweeps_d = sweeps_inc;
          end
        end
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (complete) begin
          state_d = ST_DONE;
        end else if (pause_i) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (!pause_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      pre_lat_q <= '0;
      num_lat_q <= '0;
      step_q    <= '0;
      sweeps_q  <= '0;
    end else begin
      state_q   <= state_d;
      pre_lat_q <= pre_lat_d;
      num_lat_q <= num_lat_d;
      step_q    <= step_d;
      sweeps_q  <= sweeps_d;
    end
  end

endmodule
